// File: rtl/mem_stage_sram_ctrl.sv
// Memory stage of the 5-stage pipeline: 32-bit loads/stores over a 16-bit SRAM
// bus as two half-word phases with programmable wait states, freezing the pipe via ready.
module mem_stage_sram_ctrl #(
    parameter int WAIT_CYCLES = 1,
    parameter int BASE_ADDR   = 1024,
    parameter int SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wb_in,
    input  logic               mem_read_in,
    input  logic               mem_write_in,
    input  logic [3:0]         dest,
    input  logic [31:0]        alu_res,
    input  logic [31:0]        val_rm,
    output logic               wb_out,
    output logic               mem_read_out,
    output logic [3:0]         dest_out,
    output logic [31:0]        alu_res_out,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_wdata,
    input  logic [15:0]        sram_rdata,
    output logic               sram_we_n,
    output logic               sram_oe_n
);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    localparam int            CW      = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(WAIT_CYCLES);

    state_t             state;
    state_t             state_nxt;
    logic [CW-1:0]      cnt;
    logic [31:0]        offset;
    logic [SRAM_AW-2:0] wa;
    logic               req;
    logic               is_store;
    logic               is_load;
    logic               phase_end;

    assign wb_out       = wb_in;
    assign mem_read_out = mem_read_in;
    assign dest_out     = dest;
    assign alu_res_out  = alu_res;

    // Byte offset wraps mod 2^32; the cast drops the byte-lane bits and truncates.
    assign offset    = alu_res - 32'(BASE_ADDR);
    assign wa        = (SRAM_AW-1)'(offset >> 2);
    assign req       = mem_read_in | mem_write_in;
    assign is_store  = mem_write_in;
    assign is_load   = mem_read_in & ~mem_write_in;
    assign phase_end = (cnt == CNT_MAX);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req) state_nxt = LO;
            LO:      if (phase_end) state_nxt = HI;
            HI:      if (phase_end) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        ready      = 1'b1;
        sram_we_n  = 1'b1;
        sram_oe_n  = 1'b1;
        sram_addr  = '0;
        sram_wdata = '0;
        case (state)
            IDLE: ready = ~req;
            LO: begin
                ready     = 1'b0;
                sram_addr = {wa, 1'b0};
                if (is_store) begin
                    sram_we_n  = 1'b0;
                    sram_wdata = val_rm[15:0];
                end else if (is_load) begin
                    sram_oe_n = 1'b0;
                end
            end
            HI: begin
                ready     = 1'b0;
                sram_addr = {wa, 1'b1};
                if (is_store) begin
                    sram_we_n  = 1'b0;
                    sram_wdata = val_rm[31:16];
                end else if (is_load) begin
                    sram_oe_n = 1'b0;
                end
            end
            default: ;
        endcase
        // During reset the request inputs must not pull ready low.
        if (!rst) ready = 1'b1;
    end

    // Wait-state counter and load-word assembly; each half is captured on its last phase cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            read_data <= '0;
        end else begin
            case (state)
                LO: begin
                    if (phase_end) begin
                        cnt <= '0;
                        if (is_load) read_data[15:0] <= sram_rdata;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                HI: begin
                    if (phase_end) begin
                        cnt <= '0;
                        if (is_load) read_data[31:16] <= sram_rdata;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Directed bench for mem_stage_sram_ctrl: one instance with one wait state,
// one with zero wait states, each attached to its own small SRAM model.
module tb_mem_stage_sram_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_in, mem_read_in, mem_write_in;
    logic [3:0]  dest;
    logic [31:0] alu_res, val_rm;

    logic        wb_o1, mr_o1, ready1, we_n1, oe_n1;
    logic [3:0]  dest_o1;
    logic [31:0] alu_o1, rd1;
    logic [17:0] addr1;
    logic [15:0] wdata1, rdata1;

    logic        wb_o0, mr_o0, ready0, we_n0, oe_n0;
    logic [3:0]  dest_o0;
    logic [31:0] alu_o0, rd0;
    logic [17:0] addr0;
    logic [15:0] wdata0, rdata0;

    logic        pre_we;
    logic [7:0]  pre_addr;
    logic [15:0] pre_data;
    logic [15:0] mem1 [256];
    logic [15:0] mem0 [256];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_stage_sram_ctrl #(.WAIT_CYCLES(1), .BASE_ADDR(1024), .SRAM_AW(18)) dut1 (
        .clk(clk), .rst(rst), .wb_in(wb_in), .mem_read_in(mem_read_in),
        .mem_write_in(mem_write_in), .dest(dest), .alu_res(alu_res), .val_rm(val_rm),
        .wb_out(wb_o1), .mem_read_out(mr_o1), .dest_out(dest_o1), .alu_res_out(alu_o1),
        .read_data(rd1), .ready(ready1), .sram_addr(addr1), .sram_wdata(wdata1),
        .sram_rdata(rdata1), .sram_we_n(we_n1), .sram_oe_n(oe_n1)
    );

    mem_stage_sram_ctrl #(.WAIT_CYCLES(0), .BASE_ADDR(1024), .SRAM_AW(18)) dut0 (
        .clk(clk), .rst(rst), .wb_in(wb_in), .mem_read_in(mem_read_in),
        .mem_write_in(mem_write_in), .dest(dest), .alu_res(alu_res), .val_rm(val_rm),
        .wb_out(wb_o0), .mem_read_out(mr_o0), .dest_out(dest_o0), .alu_res_out(alu_o0),
        .read_data(rd0), .ready(ready0), .sram_addr(addr0), .sram_wdata(wdata0),
        .sram_rdata(rdata0), .sram_we_n(we_n0), .sram_oe_n(oe_n0)
    );

    // Combinational-read SRAM models; the pre port loads contents while the DUTs idle.
    assign rdata1 = mem1[addr1[7:0]];
    assign rdata0 = mem0[addr0[7:0]];

    always @(posedge clk) begin
        if (pre_we) begin
            mem1[pre_addr] <= pre_data;
            mem0[pre_addr] <= pre_data;
        end else begin
            if (!we_n1) mem1[addr1[7:0]] <= wdata1;
            if (!we_n0) mem0[addr0[7:0]] <= wdata0;
        end
    end

    task automatic settle();
        mem_read_in  = 1'b0;
        mem_write_in = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; mem_read_in = 1'b1; mem_write_in = 1'b0;
        alu_res = 32'd1032; val_rm = '0; wb_in = 1'b1; dest = 4'd3;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        repeat (2) @(negedge clk);
        total++; if (ready1 !== 1'b1) begin bad++; $display("FAIL reset_ready1 got=%b exp=1", ready1); end
        total++; if (ready0 !== 1'b1) begin bad++; $display("FAIL reset_ready0 got=%b exp=1", ready0); end
        total++; if (we_n1 !== 1'b1 || oe_n1 !== 1'b1) begin bad++; $display("FAIL reset_strobes we_n=%b oe_n=%b exp=1/1", we_n1, oe_n1); end
        total++; if (rd1 !== 32'h0) begin bad++; $display("FAIL reset_read_data got=%h exp=0", rd1); end
        total++; if (addr1 !== 18'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", addr1); end
        rst = 1'b1;
        #1;
        total++; if (ready1 !== 1'b0) begin bad++; $display("FAIL release_ready got=%b exp=0", ready1); end
        @(negedge clk);
        total++; if (oe_n1 !== 1'b0 || addr1 !== 18'd4 || ready1 !== 1'b0) begin
            bad++; $display("FAIL release_in_lo oe_n=%b addr=%0d ready=%b exp=0/4/0", oe_n1, addr1, ready1);
        end
        begin
            int n = 0;
            while (ready1 !== 1'b1 && n < 20) begin @(negedge clk); n++; end
            total++; if (n >= 20) begin bad++; $display("FAIL reset_access_timeout ready=%b exp=1", ready1); end
        end
        settle();
    endtask

    task automatic test_non_memory();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            dest = 4'(i); alu_res = 32'h1000_0000 + 32'(i * 37); wb_in = i[0];
            mem_read_in = 1'b0; mem_write_in = 1'b0;
            #1;
            total++; if (ready1 !== 1'b1 || ready0 !== 1'b1) begin
                bad++; $display("FAIL nonmem_ready cyc=%0d got=%b%b exp=11", i, ready1, ready0);
            end
            total++; if (we_n1 !== 1'b1 || oe_n1 !== 1'b1 || addr1 !== 18'h0 || wdata1 !== 16'h0) begin
                bad++; $display("FAIL nonmem_bus cyc=%0d we_n=%b oe_n=%b addr=%h wd=%h exp=1/1/0/0", i, we_n1, oe_n1, addr1, wdata1);
            end
            total++; if (wb_o1 !== wb_in || mr_o1 !== 1'b0 || dest_o1 !== dest || alu_o1 !== alu_res) begin
                bad++; $display("FAIL nonmem_pass cyc=%0d wb=%b dest=%h alu=%h exp=%b/%h/%h", i, wb_o1, dest_o1, alu_o1, wb_in, dest, alu_res);
            end
        end
    endtask

    task automatic test_store();
        logic [17:0] ea;
        logic [15:0] ed;
        @(negedge clk);
        alu_res = 32'd1032; val_rm = 32'hDEADBEEF; mem_write_in = 1'b1;
        #1;
        total++; if (ready1 !== 1'b0 || we_n1 !== 1'b1) begin
            bad++; $display("FAIL store_req_cycle ready=%b we_n=%b exp=0/1", ready1, we_n1);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            ea = (c < 2) ? 18'd4 : 18'd5;
            ed = (c < 2) ? 16'hBEEF : 16'hDEAD;
            total++; if (we_n1 !== 1'b0 || oe_n1 !== 1'b1 || addr1 !== ea || wdata1 !== ed || ready1 !== 1'b0) begin
                bad++; $display("FAIL store_phase c=%0d we_n=%b oe_n=%b addr=%0d wd=%h ready=%b exp=0/1/%0d/%h/0",
                                c, we_n1, oe_n1, addr1, wdata1, ready1, ea, ed);
            end
        end
        @(negedge clk);
        total++; if (ready1 !== 1'b1 || we_n1 !== 1'b1 || addr1 !== 18'h0) begin
            bad++; $display("FAIL store_done ready=%b we_n=%b addr=%h exp=1/1/0", ready1, we_n1, addr1);
        end
        mem_write_in = 1'b0;
        @(negedge clk);
        total++; if (ready1 !== 1'b1) begin bad++; $display("FAIL store_idle_after ready=%b exp=1", ready1); end
        total++; if (mem1[4] !== 16'hBEEF || mem1[5] !== 16'hDEAD) begin
            bad++; $display("FAIL store_sram_contents lo=%h hi=%h exp=beef/dead", mem1[4], mem1[5]);
        end
        settle();
    endtask

    task automatic test_load();
        pre_we = 1'b1; pre_addr = 8'd4; pre_data = 16'h1234;
        @(negedge clk);
        pre_addr = 8'd5; pre_data = 16'hABCD;
        @(negedge clk);
        pre_we = 1'b0;
        alu_res = 32'd1032; mem_read_in = 1'b1;
        #1;
        total++; if (ready1 !== 1'b0 || oe_n1 !== 1'b1) begin
            bad++; $display("FAIL load_req_cycle ready=%b oe_n=%b exp=0/1", ready1, oe_n1);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            total++; if (oe_n1 !== 1'b0 || we_n1 !== 1'b1 || ready1 !== 1'b0 || addr1 !== ((c < 2) ? 18'd4 : 18'd5)) begin
                bad++; $display("FAIL load_phase c=%0d oe_n=%b we_n=%b ready=%b addr=%0d exp=0/1/0/%0d",
                                c, oe_n1, we_n1, ready1, addr1, (c < 2) ? 4 : 5);
            end
            if (c == 2) begin
                total++; if (rd1[15:0] !== 16'h1234) begin bad++; $display("FAIL load_lo_capture got=%h exp=1234", rd1[15:0]); end
            end
        end
        @(negedge clk);
        total++; if (rd1 !== 32'hABCD1234 || ready1 !== 1'b1 || oe_n1 !== 1'b1) begin
            bad++; $display("FAIL load_done rd=%h ready=%b oe_n=%b exp=abcd1234/1/1", rd1, ready1, oe_n1);
        end
        mem_read_in = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (rd1 !== 32'hABCD1234) begin bad++; $display("FAIL load_hold got=%h exp=abcd1234", rd1); end
        settle();
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        alu_res = 32'd1040; val_rm = 32'hCAFEF00D; mem_write_in = 1'b1;
        #1;
        total++; if (ready0 !== 1'b0) begin bad++; $display("FAIL b2b_store_req ready=%b exp=0", ready0); end
        @(negedge clk);
        total++; if (we_n0 !== 1'b0 || addr0 !== 18'd8 || wdata0 !== 16'hF00D || ready0 !== 1'b0) begin
            bad++; $display("FAIL b2b_store_lo we_n=%b addr=%0d wd=%h ready=%b exp=0/8/f00d/0", we_n0, addr0, wdata0, ready0);
        end
        @(negedge clk);
        total++; if (we_n0 !== 1'b0 || addr0 !== 18'd9 || wdata0 !== 16'hCAFE || ready0 !== 1'b0) begin
            bad++; $display("FAIL b2b_store_hi we_n=%b addr=%0d wd=%h ready=%b exp=0/9/cafe/0", we_n0, addr0, wdata0, ready0);
        end
        @(negedge clk);
        total++; if (ready0 !== 1'b1 || we_n0 !== 1'b1) begin
            bad++; $display("FAIL b2b_store_done ready=%b we_n=%b exp=1/1", ready0, we_n0);
        end
        mem_write_in = 1'b0; mem_read_in = 1'b1;
        @(negedge clk);
        total++; if (ready0 !== 1'b0 || oe_n0 !== 1'b1) begin
            bad++; $display("FAIL b2b_load_req ready=%b oe_n=%b exp=0/1", ready0, oe_n0);
        end
        @(negedge clk);
        total++; if (oe_n0 !== 1'b0 || addr0 !== 18'd8 || ready0 !== 1'b0) begin
            bad++; $display("FAIL b2b_load_lo oe_n=%b addr=%0d ready=%b exp=0/8/0", oe_n0, addr0, ready0);
        end
        @(negedge clk);
        total++; if (oe_n0 !== 1'b0 || addr0 !== 18'd9 || ready0 !== 1'b0) begin
            bad++; $display("FAIL b2b_load_hi oe_n=%b addr=%0d ready=%b exp=0/9/0", oe_n0, addr0, ready0);
        end
        @(negedge clk);
        total++; if (rd0 !== 32'hCAFEF00D || ready0 !== 1'b1) begin
            bad++; $display("FAIL b2b_load_done rd=%h ready=%b exp=cafef00d/1", rd0, ready0);
        end
        mem_read_in = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        alu_res = 32'd1032; mem_read_in = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (oe_n1 !== 1'b0 || addr1 !== 18'd5) begin
            bad++; $display("FAIL midrst_in_hi oe_n=%b addr=%0d exp=0/5", oe_n1, addr1);
        end
        rst = 1'b0;
        #1;
        total++; if (ready1 !== 1'b1 || oe_n1 !== 1'b1 || we_n1 !== 1'b1 || addr1 !== 18'h0 || rd1 !== 32'h0) begin
            bad++; $display("FAIL midrst_outputs ready=%b oe_n=%b we_n=%b addr=%h rd=%h exp=1/1/1/0/0",
                            ready1, oe_n1, we_n1, addr1, rd1);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if (ready1 !== 1'b0) begin bad++; $display("FAIL midrst_restart ready=%b exp=0", ready1); end
        repeat (4) @(negedge clk);
        total++; if (ready1 !== 1'b0 || oe_n1 !== 1'b0) begin
            bad++; $display("FAIL midrst_last_hi ready=%b oe_n=%b exp=0/0", ready1, oe_n1);
        end
        @(negedge clk);
        total++; if (rd1 !== 32'hABCD1234 || ready1 !== 1'b1) begin
            bad++; $display("FAIL midrst_load_done rd=%h ready=%b exp=abcd1234/1", rd1, ready1);
        end
        settle();
    endtask

    initial begin
        test_reset();
        test_non_memory();
        test_store();
        test_load();
        test_back_to_back();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
